// File: rtl/uart_rx_framer.sv
// UART receive framer: 2-flop synchronizer, mid-bit sampling, sticky error flags, valid/ready output.
// Optional parity checking is compiled in with `UART_RX_PARITY_EN (adds parameter PARITY_ODD).
module uart_rx_framer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    input  logic                 err_clr
);

    localparam logic [15:0] T_FULL    = 16'(CLKS_PER_BIT);
    localparam logic [15:0] T_HALF    = 16'(CLKS_PER_BIT / 2);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic        PAR_ODD   = 1'(PARITY_ODD);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q, prev_d;
    logic [1:0]           flush_q, flush_d;
    logic [15:0]          timer_q, timer_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_fail_q, par_fail_d;
    logic                 parity_err_q, parity_err_d;
    logic                 parity_set;
`endif
    logic                 fall;
    logic                 expire;
    logic                 done;
    logic                 frame_set;
    logic                 overrun_set;

    // The edge detector only trusts prev_q once the reset-time ones have flushed out of
    // the synchronizer, so a line held low across reset release never looks like a start edge.
    assign fall   = (flush_q == 2'd3) && prev_q && !sync2_q;
    assign expire = (timer_q == 16'd1);

    always_comb begin
        sync1_d     = rx_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        flush_d     = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        done        = 1'b0;
        frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_fail_d  = par_fail_q;
        parity_set  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d   = 16'd0;
                bit_cnt_d = 4'd0;
                if (fall) begin
                    state_d = S_START;
                    timer_d = T_HALF;
                end
            end
            S_START: begin
                if (!expire) begin
                    timer_d = timer_q - 16'd1;
                end else if (!sync2_q) begin
                    state_d   = S_DATA;
                    timer_d   = T_FULL;
                    bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
                    par_fail_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                    timer_d = 16'd0;
                end
            end
            S_DATA: begin
                if (!expire) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    timer_d = T_FULL;
                    shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!expire) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    timer_d = T_FULL;
                    state_d = S_STOP;
                    if (sync2_q != ((^shreg_q) ^ PAR_ODD)) begin
                        par_fail_d = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (!expire) begin
                    timer_d = timer_q - 16'd1;
                end else begin
                    timer_d   = T_FULL;
                    frame_set = !sync2_q;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = 4'd0;
                        state_d   = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                rx_data_d = shreg_q;
`ifdef UART_RX_PARITY_EN
                parity_set = par_fail_q;
`endif
                // A start edge landing in this cycle is taken right away rather than lost.
                if (fall) begin
                    state_d = S_START;
                    timer_d = T_HALF;
                end else begin
                    state_d = S_IDLE;
                    timer_d = 16'd0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                timer_d   = 16'd0;
                bit_cnt_d = 4'd0;
            end
        endcase

        overrun_set   = done && rx_valid_q && !rx_ready;
        rx_valid_d    = done || (rx_valid_q && !rx_ready);
        frame_err_d   = frame_set || (frame_err_q && !err_clr);
        overrun_err_d = overrun_set || (overrun_err_q && !err_clr);
`ifdef UART_RX_PARITY_EN
        parity_err_d  = parity_set || (parity_err_q && !err_clr);
`endif
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            flush_q       <= 2'd0;
            timer_q       <= 16'd0;
            bit_cnt_q     <= 4'd0;
            shreg_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_fail_q    <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            flush_q       <= flush_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_fail_q    <= par_fail_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: vector table, directed corner sequences and randomized frames
// scored against a word-level model of delivery, overrun and sticky flags.
module tb_uart_rx_framer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       err_clr;

    always #5 clk = ~clk;

    uart_rx_framer #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .STOP_BITS(1)
`ifdef UART_RX_PARITY_EN
        , .PARITY_ODD(0)
`endif
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .rx_in(rx_in),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun_err(overrun_err),
        .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observe rx_valid pulses: count rising edges, capture word, measure pulse length.
    int         mon_words = 0;
    logic [7:0] mon_data  = 8'h00;
    int         mon_len   = 0;
    logic       mon_prev  = 1'b0;

    always @(negedge clk) begin
        mon_prev <= rx_valid;
        if (rx_valid && !mon_prev) begin
            mon_words <= mon_words + 1;
            mon_data  <= rx_data;
            mon_len   <= 1;
        end else if (rx_valid) begin
            mon_len <= mon_len + 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        #1 rx_in = b;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par);
        @(posedge clk);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) $display("parity bit unused");
`endif
        send_bit(stop_ok);
        #1 rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    int         w0;
    logic [7:0] d;
    logic       ok;
    logic       r;
    logic       clr;
    logic       exp_rise;
    logic       m_pend;
    logic [7:0] m_data;
    logic       m_ferr;
    logic       m_ovr;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 8'h80, 1'b1};
        vecs[5] = '{8'h01, 1'b1, 8'h01, 1'b0};

        reset_b  = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_overrun_err", overrun_err, 1'b0);
        @(posedge clk);
        #1 reset_b = 1'b1;
        idle(5);

        // Table: single frames with rx_ready held high.
        for (int i = 0; i < 6; i++) begin
            w0 = mon_words;
            send_frame(vecs[i].data, vecs[i].stop_ok, ^vecs[i].data);
            idle(4);
            @(negedge clk);
            check("tbl_words", mon_words, w0 + 1);
            check("tbl_data", mon_data, vecs[i].exp_data);
            check("tbl_valid_len", mon_len, 1);
            check("tbl_valid_low", rx_valid, 1'b0);
            check("tbl_frame_err", frame_err, vecs[i].exp_ferr);
            check("tbl_parity_err", parity_err, 1'b0);
            check("tbl_overrun_err", overrun_err, 1'b0);
            if (vecs[i].exp_ferr) begin
                pulse_clr();
                @(negedge clk);
                check("tbl_clr_frame_err", frame_err, 1'b0);
            end
        end

        // Short low glitch on an idle line.
        w0 = mon_words;
        @(posedge clk);
        #1 rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_in = 1'b1;
        idle(40);
        @(negedge clk);
        check("glitch_words", mon_words, w0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_frame_err", frame_err, 1'b0);
        check("glitch_overrun_err", overrun_err, 1'b0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity needs a 1; send 0.
        w0 = mon_words;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        @(negedge clk);
        check("par_words", mon_words, w0 + 1);
        check("par_data", mon_data, 8'h07);
        check("par_parity_err", parity_err, 1'b1);
        check("par_frame_err", frame_err, 1'b0);
        pulse_clr();
        @(negedge clk);
        check("par_clr", parity_err, 1'b0);
`endif

        // Back-to-back frames with no consumer: second word overwrites the first.
        @(posedge clk);
        #1 rx_ready = 1'b0;
        w0 = mon_words;
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(4);
        @(negedge clk);
        check("ovr_words", mon_words, w0 + 1);
        check("ovr_first", mon_data, 8'h11);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_overrun_err", overrun_err, 1'b1);
        check("ovr_frame_err", frame_err, 1'b0);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        idle(2);
        @(negedge clk);
        check("ovr_consumed", rx_valid, 1'b0);
        check("ovr_sticky", overrun_err, 1'b1);

        // Reset in the middle of the data bits, then a clean frame.
        @(posedge clk);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        #1 reset_b = 1'b0;
        rx_in = 1'b1;
        #1;
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_overrun", overrun_err, 1'b0);
        check("midrst_valid", rx_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;
        idle(5);
        w0 = mon_words;
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(4);
        @(negedge clk);
        check("midrst_words", mon_words, w0 + 1);
        check("midrst_data", mon_data, 8'h5A);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_parity_err", parity_err, 1'b0);
        check("midrst_overrun_err", overrun_err, 1'b0);

        // Line held low across reset release must not start a frame.
        @(posedge clk);
        #1 reset_b = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;
        w0 = mon_words;
        idle(60);
        @(negedge clk);
        check("lowrel_words", mon_words, w0);
        check("lowrel_frame_err", frame_err, 1'b0);
        @(posedge clk);
        #1 rx_in = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(4);
        @(negedge clk);
        check("lowrel_words2", mon_words, w0 + 1);
        check("lowrel_data", mon_data, 8'h81);

        // Randomized frames scored against the word-level model.
        pulse_clr();
        @(posedge clk);
        #1 rx_ready = 1'b1;
        idle(3);
        m_pend = 1'b0;
        m_data = 8'h81;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 3) != 0);
            r   = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) == 0);
            if (clr) begin
                pulse_clr();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            @(posedge clk);
            #1 rx_ready = r;
            if (r) m_pend = 1'b0;
            idle(2);
            w0 = mon_words;
            exp_rise = !m_pend;
            send_frame(d, ok, ^d);
            idle(4);
            @(negedge clk);
            if (m_pend && !r) m_ovr = 1'b1;
            m_pend = !r;
            m_data = d;
            if (!ok) m_ferr = 1'b1;
            check("rnd_words", mon_words, w0 + (exp_rise ? 1 : 0));
            check("rnd_data", rx_data, m_data);
            check("rnd_valid", rx_valid, m_pend);
            check("rnd_frame_err", frame_err, m_ferr);
            check("rnd_overrun_err", overrun_err, m_ovr);
            check("rnd_parity_err", parity_err, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_b, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx_in, input, 1, raw asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data, output, DATA_BITS, received word, LSB = first bit on line.
REQ-008 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-009 SHALL have port rx_ready, input, 1, consumer accepts the word when rx_valid && rx_ready.
REQ-010 SHALL have port frame_err, output, 1, sticky; set on a low stop-bit sample.
REQ-011 SHALL have port parity_err, output, 1, sticky; set on a parity mismatch.
REQ-012 SHALL have port overrun_err, output, 1, sticky; set when a new word completes while rx_valid is still high.
REQ-013 SHALL have port err_clr, input, 1, single-cycle pulse; clears all sticky error flags.

Function
REQ-014 SHALL pass rx_in through a two-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-016 IDLE -> START SHALL occur on the synchronized falling edge of rx_in; the bit timer SHALL load CLKS_PER_BIT/2 (integer division).
REQ-017 In START, at timer expiry, rx_in low SHALL go to DATA with timer reload CLKS_PER_BIT; rx_in high SHALL be treated as a glitch and return to IDLE with no flags changed.
REQ-018 In DATA, at each timer expiry, SHALL sample one bit into a shift register LSB-first; after DATA_BITS samples SHALL go to PARITY if enabled, otherwise to STOP.
REQ-019 In PARITY, at timer expiry, SHALL compare the sampled bit with the configured parity of the data bits; a mismatch SHALL set the per-frame parity-fail bit.
REQ-020 In STOP, SHALL sample STOP_BITS stop bits at successive expiries; any low sample SHALL set frame_err; after the last stop bit SHALL go to DONE.
REQ-021 A frame with a framing or parity failure SHALL still be delivered on rx_data.
REQ-022 DONE SHALL last exactly one cycle, load rx_data, set rx_valid, then return to IDLE.
REQ-023 If rx_valid is already high when DONE loads, rx_data SHALL be overwritten with the new word and overrun_err SHALL be set.
REQ-024 rx_valid SHALL clear on the cycle after a cycle with rx_valid && rx_ready, unless DONE loads on that same cycle, in which case rx_valid SHALL stay high and overrun_err SHALL NOT be set.
REQ-025 A simultaneous err_clr and flag-set SHALL leave the flag set.
REQ-026 Latency from the mid-point of the last stop bit to rx_valid high SHALL be 1 cycle.
REQ-027 The receiver SHALL accept a new start edge in the cycle after DONE; back-to-back frames SHALL not be lost.

Reset
REQ-028 On reset_b low, SHALL immediately return to IDLE, including mid-frame, discarding any partial frame.
REQ-029 During reset, SHALL drive rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun_err=0, timer and bit counter = 0, and synchronizer flops = 1.
REQ-030 After reset release, a line already held low SHALL NOT start a frame until a high-to-low transition is seen.

Configuration
REQ-031 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL be present and parameter PARITY_ODD (default 0: even parity, 1: odd parity) SHALL select the parity sense.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state and PARITY_ODD SHALL be absent, and parity_err SHALL be held at 0.

Verification
REQ-033 Bench SHALL cover: CLKS_PER_BIT=16, DATA_BITS=8, frame 0xA5 with valid stop, rx_ready held high -> rx_data=0xA5 and rx_valid high for exactly 1 cycle, no flags.
REQ-034 Bench SHALL cover: a 3-cycle low glitch on rx_in -> returns to IDLE, rx_valid stays 0, no flags.
REQ-035 Bench SHALL cover: frame 0x3C with stop bit low -> rx_data=0x3C, rx_valid=1, frame_err=1; err_clr pulse -> frame_err=0.
REQ-036 Bench SHALL cover: UART_RX_PARITY_EN defined with even parity, frame 0x07 sent with parity bit 0 -> parity_err=1.
REQ-037 Bench SHALL cover: rx_ready=0 with frames 0x11 then 0x22 -> rx_data=0x22, overrun_err=1.
REQ-038 Bench SHALL cover: reset_b asserted mid-DATA, then released, then frame 0x5A sent -> rx_data=0x5A, with no stale bits and no flags.
